// File: rtl/fp_unpack_pkg.sv
// Shared FP32 field layout, classes and flag bundle for the float<->fixed
// pack/unpack blocks.
package fp_unpack_pkg;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_BIAS   = 127;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_e;

  typedef struct packed {
    logic ovf;
    logic nan;
    logic zero;
    logic unity;
  } unpack_flags_t;
endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier: zero/denormal, normal, inf, NaN, plus the
// exact +/-1.0 detect. Sign-agnostic.
module fp32_classify
  import fp_unpack_pkg::*;
(
  input  fp32_t     f,
  output fp_class_e cls,
  output logic      unity
);
  logic unused_sign;
  assign unused_sign = f.sign;

  always_comb begin
    cls = FP_NORMAL;
    if (f.exp == '0)      cls = FP_ZERO;
    else if (&f.exp)      cls = (f.mant == '0) ? FP_INF : FP_NAN;
  end

  assign unity = ({f.exp, f.mant} == 31'h3F80_0000);
endmodule

// File: rtl/fp32_fixed_unpacker_pipe.sv
// 3-stage FP32 -> signed fixed-point (OUT_W, FRAC_BITS) converter with a
// valid/ready stream. `FP_UNPACK_ROUND_NEAREST_EN selects round-to-nearest-even
// on the right-shift path instead of truncation toward zero.
module fp32_fixed_unpacker_pipe
  import fp_unpack_pkg::*;
#(
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan,
  output logic             out_zero,
  output logic             out_unity
);
  localparam int STAGES = 3;
  localparam int MAG_W  = OUT_W + 25;
  localparam logic signed [11:0] SH_OFS = 12'(FRAC_BITS - FP32_BIAS - FP32_MANT_W);
  localparam logic signed [11:0] SH_MAX = 12'(OUT_W);
  localparam logic [OUT_W-1:0] MAXP = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [MAG_W-1:0] MAXP_EXT = {{26{1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] MINN_EXT = {{25{1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

  logic [STAGES-1:0] vld_pipe;
  logic              advance;

  assign advance   = !vld_pipe[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES-1];

  // S0: raw fields
  fp32_t     f0;
  fp_class_e cls0;
  logic      unity0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      f0       <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
      f0       <= in_data;
    end
  end

  fp32_classify u_cls (.f(f0), .cls(cls0), .unity(unity0));

  // S1: align significand; shifts beyond OUT_W can only saturate
  logic signed [11:0] sh, nsh;
  logic [23:0]        sig;
  logic [MAG_W-1:0]   mag_c, mag1;
  logic               big_c, big1, sign1, unity1;
  fp_class_e          cls1;
`ifdef FP_UNPACK_ROUND_NEAREST_EN
  logic [49:0]        ext;
  logic [4:0]         nclamp;
  logic               grd_c, stk_c, grd1, stk1;
`endif

  always_comb begin
    sh    = $signed({4'b0, f0.exp}) + SH_OFS;
    nsh   = -sh;
    sig   = {1'b1, f0.mant};
    mag_c = '0;
    big_c = (cls0 == FP_INF);
`ifdef FP_UNPACK_ROUND_NEAREST_EN
    nclamp = (nsh > 12'sd26) ? 5'd26 : nsh[4:0];
    ext    = {sig, 26'b0} >> nclamp;
    grd_c  = 1'b0;
    stk_c  = 1'b0;
`endif
    if (cls0 == FP_NORMAL) begin
      if (sh > SH_MAX)  big_c = 1'b1;
      else if (!sh[11]) mag_c = MAG_W'(sig) << sh[5:0];
      else begin
`ifdef FP_UNPACK_ROUND_NEAREST_EN
        mag_c = MAG_W'(ext[49:26]);
        grd_c = ext[25];
        stk_c = |ext[24:0];
`else
        mag_c = (nsh > 12'sd24) ? '0 : MAG_W'(sig >> nsh[4:0]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag1   <= '0;
      big1   <= 1'b0;
      sign1  <= 1'b0;
      unity1 <= 1'b0;
      cls1   <= FP_ZERO;
`ifdef FP_UNPACK_ROUND_NEAREST_EN
      grd1   <= 1'b0;
      stk1   <= 1'b0;
`endif
    end else if (advance) begin
      mag1   <= mag_c;
      big1   <= big_c;
      sign1  <= f0.sign;
      unity1 <= unity0;
      cls1   <= cls0;
`ifdef FP_UNPACK_ROUND_NEAREST_EN
      grd1   <= grd_c;
      stk1   <= stk_c;
`endif
    end
  end

  // S2: round, saturate, sign
  logic [MAG_W-1:0] mag_r;
  logic [OUT_W-1:0] data_c;
  unpack_flags_t    flags_c, flags_q;

  always_comb begin
`ifdef FP_UNPACK_ROUND_NEAREST_EN
    mag_r = mag1 + MAG_W'(grd1 & (stk1 | mag1[0]));
`else
    mag_r = mag1;
`endif
    data_c  = '0;
    flags_c = '0;
    if (cls1 == FP_NAN) begin
      flags_c.nan = 1'b1;
    end else if (big1 || mag_r > MAXP_EXT) begin
      // -2^(OUT_W-1) is the one out-of-range magnitude that still fits
      if (sign1 && !big1 && mag_r == MINN_EXT) data_c = MINN;
      else begin
        data_c      = sign1 ? MINN : MAXP;
        flags_c.ovf = 1'b1;
      end
    end else begin
      data_c = sign1 ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
    end
    flags_c.zero  = (cls1 != FP_NAN) && (data_c == '0);
    flags_c.unity = unity1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      flags_q  <= '0;
    end else if (advance) begin
      out_data <= data_c;
      flags_q  <= flags_c;
    end
  end

  assign out_ovf   = flags_q.ovf;
  assign out_nan   = flags_q.nan;
  assign out_zero  = flags_q.zero;
  assign out_unity = flags_q.unity;
endmodule

// File: tb/tb_fp32_fixed_unpacker_pipe.sv
// Scoreboard bench for fp32_fixed_unpacker_pipe: real-arithmetic reference
// model, directed corner words, backpressure, random stream, mid-stream reset.
module tb_fp32_fixed_unpacker_pipe;
  localparam int OUT_W = 32;
  localparam int FRAC_BITS = 30;
  localparam logic [OUT_W-1:0] MAXP = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINN = {1'b1, {(OUT_W-1){1'b0}}};

  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] in_data = 0;
  logic [OUT_W-1:0] out_data;
  logic out_ovf, out_nan, out_zero, out_unity;

  fp32_fixed_unpacker_pipe #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_nan(out_nan),
    .out_zero(out_zero), .out_unity(out_unity));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      din;
    logic [OUT_W-1:0] data;
    logic             ovf, nan, zero, unity;
    int               issue;
    bit               lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   rnd_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Reference: value * 2^FRAC_BITS in real arithmetic, then truncate/round and clamp.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    real m, fl, fr;
    longint lm;
    int ex;
    e.din = w; e.data = '0; e.ovf = 0; e.nan = 0; e.zero = 0;
    e.unity = (w[30:0] == 31'h3F80_0000); e.issue = 0; e.lat = 0;
    ex = int'(w[30:23]);
    if (ex == 255 && w[22:0] != 0) begin
      e.nan = 1; e.unity = 0;
      return e;
    end
    if (ex == 255)    m = 1.0e300;
    else if (ex == 0) m = 0.0;
    else m = (1.0 + real'(int'(w[22:0])) / 8388608.0) * 2.0 ** (ex - 127 + FRAC_BITS);
    fl = $floor(m);
`ifdef FP_UNPACK_ROUND_NEAREST_EN
    fr = m - fl;
    if (fr > 0.5 || (fr == 0.5 && $floor(fl / 2.0) * 2.0 != fl)) fl = fl + 1.0;
`else
    fr = 0.0;
`endif
    if (fl > 2.0 ** (OUT_W - 1) - 1.0 + fr * 0.0) begin
      if (w[31] && ex != 255 && fl == 2.0 ** (OUT_W - 1)) e.data = MINN;
      else begin
        e.data = w[31] ? MINN : MAXP;
        e.ovf = 1;
      end
    end else begin
      lm = longint'(fl);
      if (w[31]) lm = -lm;
      e.data = lm[OUT_W-1:0];
    end
    e.zero = (e.data == '0);
    return e;
  endfunction

  task automatic send(input logic [31:0] w, input bit lat);
    exp_t e;
    int t = 0;
    in_valid = 1; in_data = w;
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stuck at %b for word %h", in_ready, w);
    end else begin
      e = model(w); e.issue = cyc; e.lat = lat;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  // Monitor: pops on each consumed output; checks hold stability under stall.
  bit          hold = 0;
  logic [35:0] snap;
  exp_t        em;
  always @(negedge clk) begin
    #2;
    if (!rst_n) hold = 0;
    else if (out_valid) begin
      if (out_ready) begin
        hold = 0;
        if (q.size() == 0) chk("unexpected_output", 64'(out_data), 64'hDEAD);
        else begin
          em = q.pop_front();
          chk($sformatf("result[%h]", em.din),
              64'({out_data, out_ovf, out_nan, out_zero, out_unity}),
              64'({em.data, em.ovf, em.nan, em.zero, em.unity}));
          if (em.lat) chk($sformatf("latency[%h]", em.din), 64'(cyc - em.issue), 64'd3);
        end
      end else begin
        if (hold) chk("stall_stable", 64'({out_data, out_ovf, out_nan, out_zero, out_unity}), 64'(snap));
        snap = {out_data, out_ovf, out_nan, out_zero, out_unity};
        hold = 1;
      end
    end
  end

  task automatic drain(input string nm);
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk); t++;
    end
    repeat (2) @(negedge clk);
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    logic [31:0] sp [8];
    int r = $urandom_range(0, 7);
    sp = '{32'h3F800000, 32'hBF800000, 32'hC0000000, 32'h40000000,
           32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h80000000};
    if (r == 0)      w = sp[$urandom_range(0, 7)];
    else if (r == 1) w = $urandom;
    else w = {1'($urandom_range(0, 1)), 8'($urandom_range(95, 160)), 23'($urandom)};
    return w;
  endfunction

  initial begin
    logic [31:0] dir [$];
    dir = '{32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h30800000,
            32'h350637BD, 32'h40000000, 32'hC0000000, 32'h7F800000,
            32'h7FC00000, 32'h00000001, 32'h2F800000, 32'hFF800000,
            32'h3FFFFFFF, 32'hBF000001};
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_flags", 64'({out_ovf, out_nan, out_zero, out_unity}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1;

    foreach (dir[i]) send(dir[i], 1'b1);
    drain("drain_directed");

    // Backpressure: pipe fills, in_ready drops, output held.
    out_ready = 0;
    fork
      for (int i = 0; i < 5; i++) send(32'h3F000000 + 32'(i) * 32'h00100000, 1'b0);
      begin
        repeat (3) @(negedge clk);
        #1 chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        out_ready = 1;
      end
    join
    drain("drain_backpressure");

    // Random stream with random backpressure.
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_word(), 1'b0);
          if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        rnd_on = 0;
      end
    join
    out_ready = 1;
    drain("drain_random");

    // Reset with words in flight.
    send(32'h3F800000, 1'b0);
    send(32'h3F000000, 1'b0);
    send(32'hBF000000, 1'b0);
    #3 rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_flags", 64'({out_ovf, out_nan, out_zero, out_unity}), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    send(32'hBF800000, 1'b1);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
